// File: rtl/lfsr_pkg.sv
// Shared LFSR arbiter constants, FSM state encoding and round-robin pick.
// Pure declarations and combinational helpers: no latency, no backpressure.
package lfsr_pkg;

    localparam int              LFSR_N     = 17;
    localparam logic [16:0]     LFSR_SEED  = 17'h0004b;
    localparam int              LFSR_TAP_A = 13;
    localparam int              LFSR_TAP_B = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    // First set request at or above ptr, else the lowest set request (wrap-around).
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [7:0] upper;
        logic [2:0] pick;
        logic       found;
        upper = req & (8'hFF << ptr);
        pick  = 3'd0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (upper[i]) begin
                pick  = 3'(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int i = 7; i >= 0; i--) begin
                if (req[i]) pick = 3'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/lfsr_rng_arbiter_if.sv
// Requester-side bus of the shared LFSR random-word arbiter.
// master = requester/reseed side, slave = arbiter side.
interface lfsr_rng_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 8,
    parameter int N      = 17
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic              rnd_valid;
    logic [WORD_W-1:0] rnd_data;
    logic [ID_W-1:0]   rnd_id;
    logic              seed_load;
    logic [N-1:0]      seed_val;
    logic              wrap_tick;
    logic              busy;

    modport master (
        output req, seed_load, seed_val,
        input  gnt, rnd_valid, rnd_data, rnd_id, wrap_tick, busy
    );

    modport slave (
        input  req, seed_load, seed_val,
        output gnt, rnd_valid, rnd_data, rnd_id, wrap_tick, busy
    );

endinterface

// File: rtl/lfsr_step_core.sv
// 17-bit XNOR Fibonacci LFSR register with load; steps one position per sh_en cycle.
// Load has priority over stepping; no backpressure, all control lives in the arbiter.
module lfsr_step_core
    import lfsr_pkg::*;
#(
    parameter int           N    = LFSR_N,
    parameter logic [N-1:0] SEED = LFSR_SEED
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sh_en,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] q,
    output logic [N-1:0] q_next,
    output logic         msb
);

    logic fb;

    assign fb     = ~(q[LFSR_TAP_A] ^ q[LFSR_TAP_B]);
    assign q_next = {q[N-2:0], fb};
    assign msb    = q[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= load_val;
        end else if (sh_en) begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin share of one LFSR: a grant collects WORD_W msbs, rnd_valid WORD_W+1 edges after req sampling.
// Requesters hold req until served; dropping it mid-word aborts. Optional stats: LFSR_ARB_STATS_EN.
module lfsr_rng_arbiter
    import lfsr_pkg::*;
#(
    parameter int           NREQ   = 4,
    parameter int           WORD_W = 8,
    parameter int           N      = LFSR_N,
    parameter logic [N-1:0] SEED   = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef LFSR_ARB_STATS_EN
    output logic [15:0] word_cnt,
    output logic [7:0]  abort_cnt,
`endif
    lfsr_rng_arbiter_if.slave bus
);

    localparam int                ID_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int                CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(NREQ - 1);

    arb_state_t        state, state_nxt;
    logic [NREQ-1:0]   gnt_q;
    logic [ID_W-1:0]   id_q, ptr_q, pick_id, ptr_after;
    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] rnd_shift, shift_next, rnd_data_q;
    logic [N-1:0]      seed_q, seed_clean, lfsr_q, lfsr_next, core_load_val;
    logic              lfsr_msb, sh_en, seed_ld, grant, abort, lockup, core_load;

    // All-ones is the XNOR lock-up state; never let it become the seed.
    assign seed_clean = (bus.seed_val == '1) ? SEED : bus.seed_val;
    assign pick_id    = ID_W'(rr_pick(8'(bus.req), 3'(ptr_q)));
    assign ptr_after  = (id_q == ID_LAST) ? '0 : id_q + 1'b1;

    // Unreachable from any legal seed; recovers the core if the state is ever upset.
    assign lockup        = (lfsr_q == '1);
    assign core_load     = seed_ld | lockup;
    assign core_load_val = seed_ld ? seed_clean : SEED;

    lfsr_step_core #(
        .N    (N),
        .SEED (SEED)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .sh_en    (sh_en),
        .load     (core_load),
        .load_val (core_load_val),
        .q        (lfsr_q),
        .q_next   (lfsr_next),
        .msb      (lfsr_msb)
    );

    if (WORD_W > 1) begin : g_shift_multi
        assign shift_next = {rnd_shift[WORD_W-2:0], lfsr_msb};
    end else begin : g_shift_single
        assign shift_next = lfsr_msb;
    end

    always_comb begin
        state_nxt = state;
        sh_en     = 1'b0;
        seed_ld   = 1'b0;
        grant     = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.seed_load) begin
                    seed_ld = 1'b1;
                end else if (|bus.req) begin
                    grant     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!bus.req[id_q]) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    sh_en = 1'b1;
                    if (cnt_q == CNT_LAST) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_q      <= '0;
            id_q       <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            rnd_shift  <= '0;
            rnd_data_q <= '0;
            seed_q     <= SEED;
        end else begin
            state <= state_nxt;
            if (seed_ld) seed_q <= seed_clean;
            if (grant) begin
                gnt_q <= NREQ'(1) << pick_id;
                id_q  <= pick_id;
                cnt_q <= '0;
            end
            if (sh_en) begin
                rnd_shift <= shift_next;
                cnt_q     <= cnt_q + 1'b1;
                // The finished word is published as DONE is entered so it lines up with rnd_valid.
                if (cnt_q == CNT_LAST) rnd_data_q <= shift_next;
            end
            if (abort || state == DONE) begin
                gnt_q <= '0;
                ptr_q <= ptr_after;
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rnd_valid = (state == DONE);
    assign bus.rnd_data  = rnd_data_q;
    assign bus.rnd_id    = id_q;
    assign bus.busy      = (state != IDLE);
    assign bus.wrap_tick = sh_en & (lfsr_next == seed_q);

`ifdef LFSR_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt  <= '0;
            abort_cnt <= '0;
        end else if (seed_ld) begin
            word_cnt  <= '0;
            abort_cnt <= '0;
        end else begin
            if (state == DONE && word_cnt != '1) word_cnt <= word_cnt + 1'b1;
            if (abort && abort_cnt != '1)        abort_cnt <= abort_cnt + 1'b1;
        end
    end
`endif

endmodule
